// File: rtl/hangman_pkg.sv
// Shared constants for the hangman datapath: board geometry, colour codes, op encoding
// and the screen position of each gallows part.
package hangman_pkg;

    localparam int unsigned DEF_MAX_LEN  = 8;
    localparam int unsigned DEF_MAX_MISS = 6;

    localparam logic [2:0] COL_BLANK = 3'b111;
    localparam logic [2:0] COL_FILL  = 3'b010;
    localparam logic [2:0] COL_PART  = 3'b100;

    // Letter row origin; underscores sit UNDER_DY rows below it.
    localparam int unsigned X0       = 8;
    localparam int unsigned Y0       = 8;
    localparam int unsigned CELL_GAP = 2;
    localparam int unsigned UNDER_DY = 10;

    typedef enum logic [3:0] {
        OpIdle   = 4'b0001,
        OpBlanks = 4'b0010,
        OpFill   = 4'b0100,
        OpDraw   = 4'b1000
    } op_e;

    // Returns {x[7:0], y[6:0]} of the sprite for miss number idx (1..6).
    function automatic logic [14:0] part_base(input logic [3:0] idx);
        logic [14:0] b;
        case (idx)
            4'd1:    b = {8'd120, 7'd10};
            4'd2:    b = {8'd120, 7'd30};
            4'd3:    b = {8'd104, 7'd30};
            4'd4:    b = {8'd136, 7'd30};
            4'd5:    b = {8'd104, 7'd50};
            4'd6:    b = {8'd136, 7'd50};
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pixel_sweep.sv
// Rectangle rasteriser: after start, emits w*h pixel coordinates (x fastest) one per cycle.
// done is high on the last pixel cycle; clear aborts immediately.
module pixel_sweep (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       start,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [7:0] w,
    input  logic [6:0] h,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plot,
    output logic       done
);

    logic       busy_q;
    logic [7:0] cx_q;
    logic [6:0] cy_q;
    logic       last;

    assign last = (cx_q == w - 8'd1) && (cy_q == h - 7'd1);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            busy_q <= 1'b0;
            cx_q   <= '0;
            cy_q   <= '0;
        end else if (!busy_q) begin
            if (start && w != '0 && h != '0) begin
                busy_q <= 1'b1;
                cx_q   <= '0;
                cy_q   <= '0;
            end
        end else if (last) begin
            busy_q <= 1'b0;
            cx_q   <= '0;
            cy_q   <= '0;
        end else if (cx_q == w - 8'd1) begin
            cx_q <= '0;
            cy_q <= cy_q + 7'd1;
        end else begin
            cx_q <= cx_q + 8'd1;
        end
    end

    assign plot = busy_q;
    assign done = busy_q && last;
    assign x    = busy_q ? base_x + cx_q : '0;
    assign y    = busy_q ? base_y + cy_q : '0;

endmodule

// File: rtl/hangman_datapath.sv
// Hangman datapath: stores the word, scores guesses, tracks misses and the game timer,
// and renders underscores, revealed letters and gallows parts through one shared sweeper.
module hangman_datapath
    import hangman_pkg::*;
#(
    parameter int unsigned MAX_LEN        = DEF_MAX_LEN,
    parameter int unsigned MAX_MISS       = DEF_MAX_MISS,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CELL_W         = 8,
    parameter int unsigned CELL_H         = 8,
    parameter int unsigned PART_W         = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    input  logic       writeorread,
    input  logic       wren,
    input  logic       ld_g,
    input  logic       compare,
    input  logic       timecount,
    input  logic       fill,
    input  logic       draw,
    input  logic       over,
    output logic       graph_loaded,
    output logic       match,
    output logic       filled,
    output logic       continuous,
    output logic       finish,
    output logic       complete,
    output logic       timeout,
    output logic [3:0] part,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CELL_PITCH = CELL_W + CELL_GAP;

    logic [7:0]         word_q [MAX_LEN];
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] revealed_q, hit_q, cell_mask_q;
    logic [MAX_LEN-1:0] len_mask, hit_n, new_hits, cell_onehot, cell_rest;
    logic [IDX_W-1:0]   cell_idx;
    logic [3:0]         miss_q;
    logic [CNT_W-1:0]   timer_q;
    op_e                op_q;
    logic               go_q;
    logic               ld_g_q, fill_q, draw_q;
    logic               graph_loaded_q, match_q, filled_q, finish_q, timeout_q;

    logic       sw_plot, sw_done;
    logic [7:0] sw_bx, sw_w, cell_x, part_x;
    logic [6:0] sw_by, sw_h, part_y;
    logic [2:0] colour;
    logic       load_en;

    assign load_en = writeorread && wren && !compare && char_valid;

    always_comb begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = LEN_W'(i) < len_q;
            hit_n[i]    = len_mask[i] && (word_q[i] == char_in);
        end
    end

    assign new_hits = hit_q & ~revealed_q;

    // Lowest pending cell is swept first, giving left-to-right order.
    always_comb begin
        cell_idx = '0;
        for (int i = int'(MAX_LEN) - 1; i >= 0; i--) begin
            if (cell_mask_q[i]) cell_idx = IDX_W'(i);
        end
    end

    assign cell_onehot = MAX_LEN'(1) << cell_idx;
    assign cell_rest   = cell_mask_q & ~cell_onehot;
    assign cell_x      = 8'(X0) + 8'(cell_idx) * 8'(CELL_PITCH);
    assign {part_x, part_y} = part_base(miss_q);

    always_comb begin
        sw_bx  = '0;
        sw_by  = '0;
        sw_w   = '0;
        sw_h   = '0;
        colour = '0;
        unique case (op_q)
            OpBlanks: begin
                sw_bx  = cell_x;
                sw_by  = 7'(Y0 + UNDER_DY);
                sw_w   = 8'(CELL_W);
                sw_h   = 7'(CELL_H);
                colour = COL_BLANK;
            end
            OpFill: begin
                sw_bx  = cell_x;
                sw_by  = 7'(Y0);
                sw_w   = 8'(CELL_W);
                sw_h   = 7'(CELL_H);
                colour = COL_FILL;
            end
            OpDraw: begin
                sw_bx  = part_x;
                sw_by  = part_y;
                sw_w   = 8'(PART_W);
                sw_h   = 7'(PART_W);
                colour = COL_PART;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ld_g_q <= 1'b0;
            fill_q <= 1'b0;
            draw_q <= 1'b0;
        end else begin
            ld_g_q <= ld_g;
            fill_q <= fill;
            draw_q <= draw;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || over) begin
            for (int i = 0; i < int'(MAX_LEN); i++) word_q[i] <= '0;
            len_q          <= '0;
            revealed_q     <= '0;
            hit_q          <= '0;
            cell_mask_q    <= '0;
            miss_q         <= '0;
            timer_q        <= '0;
            op_q           <= OpIdle;
            go_q           <= 1'b0;
            graph_loaded_q <= 1'b0;
            match_q        <= 1'b0;
            filled_q       <= 1'b0;
            finish_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            go_q <= 1'b0;
            if (load_en && len_q != LEN_W'(MAX_LEN)) begin
                for (int i = 0; i < int'(MAX_LEN); i++) begin
                    if (LEN_W'(i) == len_q) word_q[i] <= char_in;
                end
                len_q <= len_q + 1'b1;
            end
            if (compare && char_valid) begin
                hit_q   <= hit_n;
                match_q <= |hit_n;
            end
            if (timecount && !timeout_q) begin
                if (timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
                else timer_q <= timer_q + 1'b1;
            end
            if (!fill) filled_q <= 1'b0;
            if (!draw) finish_q <= 1'b0;

            unique case (op_q)
                OpIdle: begin
                    if (ld_g && !ld_g_q) begin
                        if (len_q == '0) begin
                            graph_loaded_q <= 1'b1;
                        end else begin
                            cell_mask_q <= len_mask;
                            op_q        <= OpBlanks;
                            go_q        <= 1'b1;
                        end
                    end else if (fill && !fill_q) begin
                        if (new_hits == '0) begin
                            filled_q <= 1'b1;
                        end else begin
                            cell_mask_q <= new_hits;
                            op_q        <= OpFill;
                            go_q        <= 1'b1;
                        end
                    end else if (draw && !draw_q) begin
                        if (miss_q != 4'(MAX_MISS)) miss_q <= miss_q + 4'd1;
                        op_q <= OpDraw;
                        go_q <= 1'b1;
                    end
                end
                OpBlanks, OpFill: begin
                    if (sw_done) begin
                        cell_mask_q <= cell_rest;
                        if (op_q == OpFill) revealed_q <= revealed_q | cell_onehot;
                        if (cell_rest == '0) begin
                            op_q <= OpIdle;
                            if (op_q == OpBlanks) graph_loaded_q <= 1'b1;
                            else filled_q <= 1'b1;
                        end else begin
                            go_q <= 1'b1;
                        end
                    end
                end
                OpDraw: begin
                    if (sw_done) begin
                        op_q     <= OpIdle;
                        finish_q <= 1'b1;
                    end
                end
                default: op_q <= OpIdle;
            endcase
        end
    end

    pixel_sweep u_sweep (
        .clk    (clk),
        .resetn (resetn),
        .clear  (over),
        .start  (go_q),
        .base_x (sw_bx),
        .base_y (sw_by),
        .w      (sw_w),
        .h      (sw_h),
        .x      (vga_x),
        .y      (vga_y),
        .plot   (sw_plot),
        .done   (sw_done)
    );

    assign vga_plot     = sw_plot;
    assign vga_colour   = sw_plot ? colour : 3'b000;
    assign graph_loaded = graph_loaded_q;
    assign match        = match_q;
    assign filled       = filled_q;
    assign finish       = finish_q;
    assign timeout      = timeout_q;
    assign part         = miss_q;
    assign complete     = (miss_q == 4'(MAX_MISS));
    assign continuous   = (len_q != '0) && ((revealed_q | ~len_mask) != '1);

endmodule

// File: tb/tb_hangman_datapath.sv
// Bench for hangman_datapath: table of guesses plus hand-written corner sequences;
// every plotted pixel is checked against a queue of expected pixels.
module tb_hangman_datapath;

    localparam int CW = 2;
    localparam int CH = 2;
    localparam int PW = 2;
    localparam int BX0 = 8;
    localparam int BY0 = 8;
    localparam int PITCH = CW + 2;
    localparam int UNDER_Y = BY0 + 10;

    logic       clk = 1'b0;
    logic       resetn, char_valid, writeorread, wren, ld_g, compare, timecount;
    logic       fill, draw, over;
    logic [7:0] char_in;
    logic       graph_loaded, match, filled, continuous, finish, complete, timeout;
    logic [3:0] part;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int checks = 0;
    int failures = 0;
    int plot_cnt = 0;
    logic [17:0] exp_q[$];
    logic [17:0] pix_exp;

    typedef struct {
        byte        ch;
        logic       exp_match;
        logic       do_fill;
        logic       do_draw;
        logic [7:0] cells;
        logic       exp_cont;
        int         exp_part;
        logic       exp_complete;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    hangman_datapath #(
        .CELL_W         (CW),
        .CELL_H         (CH),
        .PART_W         (PW),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .writeorread  (writeorread),
        .wren         (wren),
        .ld_g         (ld_g),
        .compare      (compare),
        .timecount    (timecount),
        .fill         (fill),
        .draw         (draw),
        .over         (over),
        .graph_loaded (graph_loaded),
        .match        (match),
        .filled       (filled),
        .continuous   (continuous),
        .finish       (finish),
        .complete     (complete),
        .timeout      (timeout),
        .part         (part),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot)
    );

    always @(negedge clk) begin
        if (vga_plot === 1'b1) begin
            plot_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pixel_unexpected got x=%0d y=%0d c=%0d required none",
                         vga_x, vga_y, vga_colour);
            end else begin
                pix_exp = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== pix_exp) begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                             vga_x, vga_y, vga_colour, pix_exp[17:10], pix_exp[9:3],
                             pix_exp[2:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rect(input int bx, input int by, input int w, input int h,
                             input logic [2:0] c);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                exp_q.push_back({8'(bx + xx), 7'(by + yy), c});
    endtask

    task automatic push_part(input int idx);
        int px[7] = '{0, 120, 120, 104, 136, 104, 136};
        int py[7] = '{0, 10, 30, 30, 30, 50, 50};
        push_rect(px[idx], py[idx], PW, PW, 3'b100);
    endtask

    task automatic wait_flag(input int which, input string nm);
        logic v;
        int n;
        n = 0;
        v = 1'b0;
        while (n < 400) begin
            case (which)
                0: v = graph_loaded;
                1: v = filled;
                2: v = finish;
                default: v = vga_plot;
            endcase
            if (v === 1'b1) break;
            tick();
            n++;
        end
        check(nm, 32'(v), 1);
    endtask

    task automatic load_char(input byte c);
        writeorread = 1'b1;
        wren = 1'b1;
        char_valid = 1'b1;
        char_in = c;
        tick();
        writeorread = 1'b0;
        wren = 1'b0;
        char_valid = 1'b0;
    endtask

    task automatic guess(input byte c);
        compare = 1'b1;
        char_valid = 1'b1;
        char_in = c;
        tick();
        compare = 1'b0;
        char_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"A", 1'b1, 1'b1, 1'b0, 8'b010, 1'b1, 0, 1'b0};
        vecs[1]  = '{"Z", 1'b0, 1'b0, 1'b1, 8'b000, 1'b1, 1, 1'b0};
        vecs[2]  = '{"A", 1'b1, 1'b1, 1'b0, 8'b000, 1'b1, 1, 1'b0};
        vecs[3]  = '{"C", 1'b1, 1'b1, 1'b0, 8'b001, 1'b1, 1, 1'b0};
        vecs[4]  = '{"T", 1'b1, 1'b1, 1'b0, 8'b100, 1'b0, 1, 1'b0};
        vecs[5]  = '{"Q", 1'b0, 1'b0, 1'b1, 8'b000, 1'b0, 2, 1'b0};
        vecs[6]  = '{"W", 1'b0, 1'b0, 1'b1, 8'b000, 1'b0, 3, 1'b0};
        vecs[7]  = '{"E", 1'b0, 1'b0, 1'b1, 8'b000, 1'b0, 4, 1'b0};
        vecs[8]  = '{"R", 1'b0, 1'b0, 1'b1, 8'b000, 1'b0, 5, 1'b0};
        vecs[9]  = '{"Y", 1'b0, 1'b0, 1'b1, 8'b000, 1'b0, 6, 1'b1};
        vecs[10] = '{"X", 1'b0, 1'b0, 1'b1, 8'b000, 1'b0, 6, 1'b1};

        resetn = 1'b0;
        char_in = '0;
        char_valid = 1'b0;
        writeorread = 1'b0;
        wren = 1'b0;
        ld_g = 1'b0;
        compare = 1'b0;
        timecount = 1'b0;
        fill = 1'b0;
        draw = 1'b0;
        over = 1'b0;
        repeat (3) tick();
        check("rst_graph_loaded", 32'(graph_loaded), 0);
        check("rst_match", 32'(match), 0);
        check("rst_continuous", 32'(continuous), 0);
        check("rst_part", 32'(part), 0);
        check("rst_complete", 32'(complete), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_plot", 32'(vga_plot), 0);
        resetn = 1'b1;
        tick();

        load_char("C");
        load_char("A");
        load_char("T");
        check("cat_continuous", 32'(continuous), 1);
        for (int i = 0; i < 3; i++) push_rect(BX0 + i * PITCH, UNDER_Y, CW, CH, 3'b111);
        plot_cnt = 0;
        ld_g = 1'b1;
        wait_flag(0, "blanks_graph_loaded");
        check("blanks_plot_cnt", 32'(plot_cnt), 12);
        check("blanks_queue_empty", 32'(exp_q.size()), 0);
        ld_g = 1'b0;
        tick();
        check("graph_loaded_sticky", 32'(graph_loaded), 1);

        for (int v = 0; v < 11; v++) begin
            guess(vecs[v].ch);
            check($sformatf("match_v%0d", v), 32'(match), 32'(vecs[v].exp_match));
            if (vecs[v].do_fill) begin
                for (int i = 0; i < 8; i++)
                    if (vecs[v].cells[i]) push_rect(BX0 + i * PITCH, BY0, CW, CH, 3'b010);
                fill = 1'b1;
                wait_flag(1, $sformatf("filled_v%0d", v));
                check($sformatf("fill_queue_v%0d", v), 32'(exp_q.size()), 0);
                fill = 1'b0;
                tick();
                check($sformatf("filled_low_v%0d", v), 32'(filled), 0);
            end
            if (vecs[v].do_draw) begin
                push_part(vecs[v].exp_part);
                draw = 1'b1;
                wait_flag(2, $sformatf("finish_v%0d", v));
                check($sformatf("draw_queue_v%0d", v), 32'(exp_q.size()), 0);
                tick();
                tick();
                check($sformatf("finish_held_v%0d", v), 32'(finish), 1);
                draw = 1'b0;
                tick();
                check($sformatf("finish_low_v%0d", v), 32'(finish), 0);
            end
            check($sformatf("part_v%0d", v), 32'(part), 32'(vecs[v].exp_part));
            check($sformatf("complete_v%0d", v), 32'(complete), 32'(vecs[v].exp_complete));
            check($sformatf("continuous_v%0d", v), 32'(continuous), 32'(vecs[v].exp_cont));
        end

        timecount = 1'b1;
        repeat (19) tick();
        check("timeout_before", 32'(timeout), 0);
        tick();
        check("timeout_at_20", 32'(timeout), 1);
        timecount = 1'b0;
        repeat (3) tick();
        check("timeout_sticky", 32'(timeout), 1);

        over = 1'b1;
        tick();
        over = 1'b0;
        check("over_graph_loaded", 32'(graph_loaded), 0);
        check("over_match", 32'(match), 0);
        check("over_filled", 32'(filled), 0);
        check("over_finish", 32'(finish), 0);
        check("over_complete", 32'(complete), 0);
        check("over_timeout", 32'(timeout), 0);
        check("over_part", 32'(part), 0);
        check("over_continuous", 32'(continuous), 0);

        for (int i = 0; i < 9; i++) load_char(8'("A" + i));
        check("long_continuous", 32'(continuous), 1);
        for (int i = 0; i < 8; i++) push_rect(BX0 + i * PITCH, UNDER_Y, CW, CH, 3'b111);
        plot_cnt = 0;
        ld_g = 1'b1;
        wait_flag(0, "long_graph_loaded");
        check("long_plot_cnt", 32'(plot_cnt), 32);
        ld_g = 1'b0;
        tick();
        guess("I");
        check("ninth_ignored", 32'(match), 0);
        guess("H");
        check("eighth_stored", 32'(match), 1);

        push_part(1);
        draw = 1'b1;
        wait_flag(3, "draw_started");
        resetn = 1'b0;
        tick();
        check("midreset_plot", 32'(vga_plot), 0);
        check("midreset_part", 32'(part), 0);
        resetn = 1'b1;
        draw = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        check("midreset_quiet", 32'(vga_plot), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
